// File: rtl/dequantizer_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dequantizer_pipe
//  Description : Rebuilds wide signed fixed-point values from a quantized tile
//                and its per-tile max_num scale:
//                  y = sat(round_half_up(q * max_num / 2^(IN_WIDTH-1)))
//                Two-stage elastic valid/ready pipeline (multiply, then
//                round/shift/saturate), full throughput, last-tile tagging
//                every BLOCK_TILES output tiles.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                data_in[N]          - signed quantized elements (N = IN_PARALLELISM*IN_SIZE)
//                max_num_in          - unsigned tile scale, travels with data_in
//                data_in_valid/ready - input handshake
//                data_out[N]         - signed dequantized elements
//                max_num_out         - scale travelling with data_out
//                data_out_valid/ready- output handshake
//                data_out_last       - marks the final tile of each block
//  Revision    : 1.0 - initial release
// ============================================================================
module dequantizer_pipe #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int MAX_NUM_WIDTH  = 16,
  parameter int OUT_WIDTH      = 16,
  parameter int BLOCK_TILES    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      data_in [IN_PARALLELISM*IN_SIZE-1:0],
  input  logic [MAX_NUM_WIDTH-1:0] max_num_in,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [OUT_WIDTH-1:0]     data_out [IN_PARALLELISM*IN_SIZE-1:0],
  output logic [MAX_NUM_WIDTH-1:0] max_num_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic                     data_out_last
);

  localparam int c_N     = IN_PARALLELISM * IN_SIZE;
  // Product width: signed q times zero-extended (hence signed) scale.
  localparam int c_PW    = IN_WIDTH + MAX_NUM_WIDTH + 1;
  // One guard bit so adding the rounding offset can never overflow.
  localparam int c_SW    = c_PW + 1;
  localparam int c_SHIFT = IN_WIDTH - 1;
  localparam int c_CW    = (BLOCK_TILES > 1) ? $clog2(BLOCK_TILES) : 1;

  localparam logic signed [c_SW-1:0] c_HALF    = c_SW'(1) << (IN_WIDTH - 2);
  localparam logic signed [c_SW-1:0] c_OUT_MAX = c_SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  // Bitwise inverse of 0..011..1 is 1..100..0, i.e. -2^(OUT_WIDTH-1).
  localparam logic signed [c_SW-1:0] c_OUT_MIN = ~c_OUT_MAX;
  localparam logic [c_CW-1:0]        c_CNT_LAST = c_CW'(BLOCK_TILES - 1);

  // Stage 1: products and scale
  logic                            s1_valid_q, s1_valid_d;
  logic signed [c_PW-1:0]          p_q [c_N-1:0];
  logic signed [c_PW-1:0]          p_d [c_N-1:0];
  logic [MAX_NUM_WIDTH-1:0]        s1_scale_q, s1_scale_d;

  // Stage 2: rounded/saturated results and scale
  logic                            s2_valid_q, s2_valid_d;
  logic [OUT_WIDTH-1:0]            r_q [c_N-1:0];
  logic [OUT_WIDTH-1:0]            r_d [c_N-1:0];
  logic [MAX_NUM_WIDTH-1:0]        s2_scale_q, s2_scale_d;

  // Output-handshake tile counter within the current block
  logic [c_CW-1:0]                 cnt_q, cnt_d;

  logic                            w_s1_ready;
  logic                            w_s2_ready;
  logic                            w_in_fire;
  logic                            w_out_fire;
  logic                            w_cnt_at_last;
  logic signed [c_SW-1:0]          w_sum   [c_N-1:0];
  logic signed [c_SW-1:0]          w_shift [c_N-1:0];
  logic [OUT_WIDTH-1:0]            w_sat   [c_N-1:0];

  // Handshake chain: a stage can take new data if empty or if it drains now.
  assign w_s2_ready    = !s2_valid_q || data_out_ready;
  assign w_s1_ready    = !s1_valid_q || w_s2_ready;
  assign data_in_ready = w_s1_ready && !rst;
  assign w_in_fire     = data_in_valid && data_in_ready;
  assign w_out_fire    = s2_valid_q && data_out_ready;
  assign w_cnt_at_last = (cnt_q == c_CNT_LAST);

  // Round half up, arithmetic shift, then clamp into the output range.
  always_comb begin
    for (int i = 0; i < c_N; i++) begin
      w_sum[i]   = {p_q[i][c_PW-1], p_q[i]} + c_HALF;
      w_shift[i] = w_sum[i] >>> c_SHIFT;
      if (w_shift[i] > c_OUT_MAX) begin
        w_sat[i] = c_OUT_MAX[OUT_WIDTH-1:0];
      end else if (w_shift[i] < c_OUT_MIN) begin
        w_sat[i] = c_OUT_MIN[OUT_WIDTH-1:0];
      end else begin
        w_sat[i] = w_shift[i][OUT_WIDTH-1:0];
      end
    end
  end

  // Next-state: each stage holds unless its downstream side lets it move.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_scale_d = s1_scale_q;
    s2_valid_d = s2_valid_q;
    s2_scale_d = s2_scale_q;
    cnt_d      = cnt_q;
    for (int i = 0; i < c_N; i++) begin
      p_d[i] = p_q[i];
      r_d[i] = r_q[i];
    end

    if (w_s1_ready) begin
      s1_valid_d = w_in_fire;
    end
    if (w_in_fire) begin
      s1_scale_d = max_num_in;
      for (int i = 0; i < c_N; i++) begin
        p_d[i] = c_PW'($signed(data_in[i])) * c_PW'($signed({1'b0, max_num_in}));
      end
    end

    if (w_s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
    if (w_s2_ready && s1_valid_q) begin
      s2_scale_d = s1_scale_q;
      for (int i = 0; i < c_N; i++) begin
        r_d[i] = w_sat[i];
      end
    end

    if (w_out_fire) begin
      cnt_d = w_cnt_at_last ? '0 : cnt_q + c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_scale_q <= '0;
      s2_valid_q <= 1'b0;
      s2_scale_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < c_N; i++) begin
        p_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_scale_q <= s1_scale_d;
      s2_valid_q <= s2_valid_d;
      s2_scale_q <= s2_scale_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < c_N; i++) begin
        p_q[i] <= p_d[i];
        r_q[i] <= r_d[i];
      end
    end
  end

  assign data_out       = r_q;
  assign max_num_out    = s2_scale_q;
  assign data_out_valid = s2_valid_q;
  assign data_out_last  = s2_valid_q && w_cnt_at_last;

endmodule
`default_nettype wire
